// File: rtl/pump_pkg.sv
// Shared definitions for the pump lead/lag scheduler.
// State encodings, millisecond counter width and a saturating increment.
package pump_pkg;

  localparam int MS_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef logic [MS_CNT_W-1:0] ms_cnt_t;

  function automatic ms_cnt_t sat_inc(ms_cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every millisecond.
// With CLK_HZ = 1000 the tick is high on every cycle.
module ms_tick_gen #(
  parameter int CLK_HZ = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pump_lead_lag_scheduler.sv
// Two-pump lead/lag scheduler with min on/off, run cap swap and failover.
// Pump drives are registered from the next state so they move with it.
module pump_lead_lag_scheduler
  import pump_pkg::*;
#(
  parameter int CLK_HZ     = 1_000_000,
  parameter int MIN_ON_MS  = 2000,
  parameter int MIN_OFF_MS = 5000,
  parameter int MAX_RUN_MS = 60000,
  parameter int DEAD_MS    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pump_req,
  input  logic       en_auto,
  input  logic       fault,
  input  logic       avail_a,
  input  logic       avail_b,
  output logic       pump_a_on,
  output logic       pump_b_on,
  output logic       lead_b,
  output logic [1:0] state_o,
  output logic       no_pump_alarm,
  output logic [7:0] run_cycles
);

  localparam ms_cnt_t MIN_ON  = ms_cnt_t'(MIN_ON_MS);
  localparam ms_cnt_t MIN_OFF = ms_cnt_t'(MIN_OFF_MS);
  localparam ms_cnt_t MAX_RUN = ms_cnt_t'(MAX_RUN_MS);
  localparam ms_cnt_t DEAD_T  = ms_cnt_t'(DEAD_MS);

  state_t     state, nxt;
  logic       sel, sel_n, lead_n, cyc_inc;
  logic       tick, ok, act_ok, oth_ok;
  logic [1:0] avail;
  ms_cnt_t    off_cnt, run_cnt, dead_cnt;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign ok      = en_auto & ~fault;
  assign avail   = {avail_b, avail_a};
  assign act_ok  = avail[sel];
  assign oth_ok  = avail[~sel];
  assign state_o = state;

  always_comb begin
    nxt     = state;
    sel_n   = sel;
    lead_n  = lead_b;
    cyc_inc = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pump_req && ok && (avail_a || avail_b)
            && off_cnt >= MIN_OFF) begin
          nxt   = ST_RUN;
          sel_n = avail[lead_b] ? lead_b : ~lead_b;
        end
      end
      ST_RUN: begin
        if (!ok) begin
          nxt     = ST_IDLE;
          cyc_inc = 1'b1;
        end else if (!act_ok) begin
          nxt = (oth_ok && pump_req) ? ST_DEAD : ST_IDLE;
        end else if (!pump_req && run_cnt >= MIN_ON) begin
          nxt     = ST_IDLE;
          lead_n  = ~lead_b;
          cyc_inc = 1'b1;
        end else if (run_cnt >= MAX_RUN && oth_ok) begin
          nxt    = ST_DEAD;
          lead_n = ~lead_b;
        end
      end
      ST_DEAD: begin
        if (!ok || !pump_req || !oth_ok) begin
          nxt = ST_IDLE;
        end else if (dead_cnt >= DEAD_T) begin
          nxt   = ST_RUN;
          sel_n = ~sel;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      sel           <= 1'b0;
      lead_b        <= 1'b0;
      off_cnt       <= MIN_OFF;
      run_cnt       <= '0;
      dead_cnt      <= '0;
      run_cycles    <= '0;
      pump_a_on     <= 1'b0;
      pump_b_on     <= 1'b0;
      no_pump_alarm <= 1'b0;
    end else begin
      state         <= nxt;
      sel           <= sel_n;
      lead_b        <= lead_n;
      run_cycles    <= run_cycles + {7'd0, cyc_inc};
      pump_a_on     <= (nxt == ST_RUN) & ~sel_n;
      pump_b_on     <= (nxt == ST_RUN) & sel_n;
      no_pump_alarm <= pump_req & ok & ~avail_a & ~avail_b;
      if (state == ST_RUN && nxt != ST_RUN) begin
        off_cnt <= '0;
      end else if (state == ST_IDLE && tick) begin
        off_cnt <= sat_inc(off_cnt);
      end
      if (nxt == ST_RUN && state != ST_RUN) begin
        run_cnt <= '0;
      end else if (state == ST_RUN && tick) begin
        run_cnt <= sat_inc(run_cnt);
      end
      if (nxt == ST_DEAD && state != ST_DEAD) begin
        dead_cnt <= '0;
      end else if (state == ST_DEAD && tick) begin
        dead_cnt <= sat_inc(dead_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pump_lead_lag_scheduler.sv
// Bench for pump_lead_lag_scheduler: directed scenarios then random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_pump_lead_lag_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pump_req = 1'b0;
  logic       en_auto = 1'b0;
  logic       fault = 1'b0;
  logic       avail_a = 1'b1;
  logic       avail_b = 1'b1;
  logic       pump_a_on, pump_b_on, lead_b, no_pump_alarm;
  logic [1:0] state_o;
  logic [7:0] run_cycles;

  always #5 clk = ~clk;

  pump_lead_lag_scheduler #(
    .CLK_HZ     (1000),
    .MIN_ON_MS  (5),
    .MIN_OFF_MS (8),
    .MAX_RUN_MS (20),
    .DEAD_MS    (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pump_req      (pump_req),
    .en_auto       (en_auto),
    .fault         (fault),
    .avail_a       (avail_a),
    .avail_b       (avail_b),
    .pump_a_on     (pump_a_on),
    .pump_b_on     (pump_b_on),
    .lead_b        (lead_b),
    .state_o       (state_o),
    .no_pump_alarm (no_pump_alarm),
    .run_cycles    (run_cycles)
  );

  localparam int T_ON = 5, T_OFF = 8, T_MAX = 20, T_DEAD = 2;

  int vecs = 0;
  int errs = 0;

  // model: mode 0 idle, 1 run, 2 dead; times in ms
  int m_mode, m_pump, m_lead, m_idle_ms, m_run_ms, m_dead_ms;
  int m_cycles, m_alarm;

  function automatic int sat(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_pump = 0; m_lead = 0;
    m_idle_ms = T_OFF; m_run_ms = 0; m_dead_ms = 0;
    m_cycles = 0; m_alarm = 0;
  endtask

  task automatic m_step();
    bit ok;
    bit av [2];
    ok = en_auto && !fault;
    av[0] = avail_a;
    av[1] = avail_b;
    m_alarm = (pump_req && ok && !avail_a && !avail_b) ? 1 : 0;
    if (m_mode == 0) begin
      if (pump_req && ok && (avail_a || avail_b) && m_idle_ms >= T_OFF) begin
        m_mode = 1;
        m_run_ms = 0;
        m_pump = av[m_lead] ? m_lead : 1 - m_lead;
      end
      m_idle_ms = sat(m_idle_ms);
    end else if (m_mode == 1) begin
      if (!ok) begin
        m_mode = 0; m_cycles = (m_cycles + 1) % 256; m_idle_ms = 0;
      end else if (!av[m_pump]) begin
        m_idle_ms = 0;
        if (av[1-m_pump] && pump_req) begin
          m_mode = 2; m_dead_ms = 0;
        end else begin
          m_mode = 0;
        end
      end else if (!pump_req && m_run_ms >= T_ON) begin
        m_mode = 0; m_lead = 1 - m_lead;
        m_cycles = (m_cycles + 1) % 256; m_idle_ms = 0;
      end else if (m_run_ms >= T_MAX && av[1-m_pump]) begin
        m_mode = 2; m_lead = 1 - m_lead;
        m_dead_ms = 0; m_idle_ms = 0;
      end else begin
        m_run_ms = sat(m_run_ms);
      end
    end else begin
      if (!ok || !pump_req || !av[1-m_pump]) begin
        m_mode = 0;
      end else if (m_dead_ms >= T_DEAD) begin
        m_mode = 1; m_pump = 1 - m_pump; m_run_ms = 0;
      end else begin
        m_dead_ms = sat(m_dead_ms);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  task automatic chk(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("pump_a_on", pump_a_on, (m_mode == 1 && m_pump == 0) ? 1 : 0);
      chk("pump_b_on", pump_b_on, (m_mode == 1 && m_pump == 1) ? 1 : 0);
      chk("both_on", pump_a_on & pump_b_on, 0);
      chk("lead_b", lead_b, m_lead);
      chk("state_o", state_o, m_mode);
      chk("alarm", no_pump_alarm, m_alarm);
      chk("run_cycles", run_cycles, m_cycles);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    chk("rst_a", pump_a_on, 0);
    chk("rst_state", state_o, 0);
    rst = 1'b0;
    en_auto = 1'b1;
    pump_req = 1'b1;
    step(1);
    chk("start_a", pump_a_on, 1);
    chk("start_b", pump_b_on, 0);
    chk("start_st", state_o, 1);
    step(20);
    chk("cap_a_still_on", pump_a_on, 1);
    step(1);
    chk("swap_dead_st", state_o, 2);
    chk("swap_dead_a", pump_a_on, 0);
    chk("swap_lead", lead_b, 1);
    step(2);
    chk("swap_dead_hold", state_o, 2);
    step(1);
    chk("swap_b_on", pump_b_on, 1);
    pump_req = 1'b0;
    step(5);
    chk("minon_hold_b", pump_b_on, 1);
    step(1);
    chk("minon_stop_st", state_o, 0);
    chk("minon_cycles", run_cycles, 1);
    chk("minon_lead", lead_b, 0);
    pump_req = 1'b1;
    step(8);
    chk("minoff_lock", state_o, 0);
    step(1);
    chk("minoff_start_a", pump_a_on, 1);
    fault = 1'b1;
    step(1);
    chk("fault_off_st", state_o, 0);
    chk("fault_cycles", run_cycles, 2);
    chk("fault_lead", lead_b, 0);
    fault = 1'b0;
    step(8);
    chk("fault_lock", state_o, 0);
    step(1);
    chk("fault_restart", pump_a_on, 1);
    avail_a = 1'b0;
    step(1);
    chk("fo_dead", state_o, 2);
    step(2);
    chk("fo_dead_hold", state_o, 2);
    step(1);
    chk("fo_b_on", pump_b_on, 1);
    avail_b = 1'b0;
    step(1);
    chk("fo_idle", state_o, 0);
    chk("fo_alarm", no_pump_alarm, 1);
    avail_a = 1'b1;
    avail_b = 1'b1;
    step(9);
    chk("pre_rst_a", pump_a_on, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_a", pump_a_on, 0);
    chk("arst_b", pump_b_on, 0);
    chk("arst_lead", lead_b, 0);
    chk("arst_cycles", run_cycles, 0);
    chk("arst_state", state_o, 0);
    step(2);
    rst = 1'b0;
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(11) == 0) pump_req = ~pump_req;
      en_auto = ($urandom_range(59) != 0);
      fault = ($urandom_range(79) == 0);
      if ($urandom_range(49) == 0) avail_a = ~avail_a;
      if ($urandom_range(49) == 0) avail_b = ~avail_b;
    end
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
